// File: rtl/avalon_bus_router_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for avalon_bus_router.
//
// cpu_bus_if : CPU data port. The CPU is the master; the router is the slave.
//   ReadData / WriteData  request strobes, held by the CPU until DataDone
//   DataAddr / BusIn      address and write data
//   BusOut                registered read data
//   DataDone / DataError  one-cycle completion pulse and its error flag
//
// dev_bus_if : Avalon-style slave fabric. The router is the master; the
//              attached devices are the slaves.
//   dev_read / dev_write  one-hot read and write strobes
//   dev_addr / dev_wdata  latched slave offset and write data
//   dev_rdata             packed read data, slave i at [i*DATA_W +: DATA_W]
//   dev_waitreq           per-slave waitrequest, active-high
// ----------------------------------------------------------------------------
interface cpu_bus_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              ReadData;
  logic              WriteData;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] BusIn;
  logic [DATA_W-1:0] BusOut;
  logic              DataDone;
  logic              DataError;

  modport master (
    output ReadData, WriteData, DataAddr, BusIn,
    input  BusOut, DataDone, DataError
  );

  modport slave (
    input  ReadData, WriteData, DataAddr, BusIn,
    output BusOut, DataDone, DataError
  );
endinterface

interface dev_bus_if #(
  parameter int DATA_W  = 16,
  parameter int OFS_W   = 12,
  parameter int NUM_DEV = 3
);
  logic [NUM_DEV-1:0]        dev_read;
  logic [NUM_DEV-1:0]        dev_write;
  logic [OFS_W-1:0]          dev_addr;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;
  logic [NUM_DEV-1:0]        dev_waitreq;

  modport master (
    output dev_read, dev_write, dev_addr, dev_wdata,
    input  dev_rdata, dev_waitreq
  );

  modport slave (
    input  dev_read, dev_write, dev_addr, dev_wdata,
    output dev_rdata, dev_waitreq
  );
endinterface

// File: rtl/avalon_bus_router.sv
// ----------------------------------------------------------------------------
// avalon_bus_router
//
// Routes CPU data-port requests to one of NUM_DEV Avalon-style slaves chosen
// by the top SEL_W address bits. A request is latched in IDLE, the selected
// slave is strobed in ACCESS until it drops waitrequest (or the wait counter
// hits TIMEOUT), the response is presented for one cycle in RESP, and RELEASE
// waits for the CPU to drop its strobes so a held request is not reissued.
//
// Ports
//   Clock  clock
//   Reset  asynchronous, active-high
//   cpu    cpu_bus_if.slave  : CPU request / registered response
//   dev    dev_bus_if.master : one-hot slave strobes, offset, data, waitreq
//
// Every output comes straight from a flop; inputs reach outputs only
// through the registers.
// ----------------------------------------------------------------------------
module avalon_bus_router #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int SEL_W   = 4,
  parameter int NUM_DEV = 3,
  parameter int TIMEOUT = 255
) (
  input  logic      Clock,
  input  logic      Reset,
  cpu_bus_if.slave  cpu,
  dev_bus_if.master dev
);

  localparam int OFS_W = ADDR_W - SEL_W;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                is_write_q, is_write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_DEV-1:0]  read_q, read_d;
  logic [NUM_DEV-1:0]  write_q, write_d;
  logic [OFS_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                req;
  logic [SEL_W-1:0]    req_idx;
  logic                req_mapped;
  logic [NUM_DEV-1:0]  req_onehot;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_wait;
  logic [CNT_W:0]      cnt_inc;
  logic                timed_out;

  // Request decode and selected-slave mux. The mux is driven by the latched
  // index so late changes on DataAddr cannot redirect an access in flight.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and no latch is inferred.
    req        = cpu.ReadData | cpu.WriteData;
    req_idx    = cpu.DataAddr[ADDR_W-1 -: SEL_W];
    req_mapped = (int'(req_idx) < NUM_DEV);
    req_onehot = '0;
    sel_rdata  = '0;
    sel_wait   = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (req_idx == SEL_W'(i)) req_onehot[i] = 1'b1;
      if (idx_q == SEL_W'(i)) begin
        sel_rdata = dev.dev_rdata[i*DATA_W +: DATA_W];
        sel_wait  = dev.dev_waitreq[i];
      end
    end
    cnt_inc   = {1'b0, cnt_q} + 1'b1;
    timed_out = (TIMEOUT != 0) && (cnt_inc == (CNT_W + 1)'(TIMEOUT));
  end

  // State register plus all registered outputs and latched request fields.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: the reset branch covers every flop, including the datapath
    // latches, so slaves see strobes drop the moment Reset rises.
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      read_q     <= '0;
      write_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the same
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = req_mapped ? ACCESS : RESP;
      ACCESS:  if (!sel_wait || timed_out) state_d = RESP;
      RESP:    state_d = RELEASE;
      RELEASE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Strobes default to
  // 0 so they drop on any exit from ACCESS; response fields default to hold
  // so BusOut/DataError keep their value until the next RESP.
  always_comb begin
    idx_d      = idx_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    cnt_d      = cnt_q;
    read_d     = '0;
    write_d    = '0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Both strobes high is treated as a write.
          idx_d      = req_idx;
          is_write_d = cpu.WriteData;
          addr_d     = cpu.DataAddr[OFS_W-1:0];
          wdata_d    = cpu.BusIn;
          cnt_d      = '0;
          if (req_mapped) begin
            read_d  = cpu.WriteData ? '0 : req_onehot;
            write_d = cpu.WriteData ? req_onehot : '0;
          end else begin
            rdata_d = '0;
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!sel_wait) begin
          if (!is_write_q) rdata_d = sel_rdata;
          error_d = 1'b0;
          done_d  = 1'b1;
        end else if (timed_out) begin
          rdata_d = '0;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          read_d  = read_q;
          write_d = write_q;
          // Saturate rather than wrap when TIMEOUT is 0 (timeout disabled).
          if (cnt_q != CNT_MAX) cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  assign cpu.BusOut    = rdata_q;
  assign cpu.DataDone  = done_q;
  assign cpu.DataError = error_q;
  assign dev.dev_read  = read_q;
  assign dev.dev_write = write_q;
  assign dev.dev_addr  = addr_q;
  assign dev.dev_wdata = wdata_q;

endmodule
